game_sequencer: RTL and testbench

- Game-flow controller that owns the control bus consumed by the screen multiplexer and drawing blocks.
- Fields driven: game_state, game_mode, round_counter, score, is_scored.
- Sequences START -> alternating SHOOTER/KEEPER kicks -> WINNER/LOOSER using penalty-shootout rules, including early decision and sudden death.
- Holds each kick result for a fixed number of frames so the result is visible on screen.

---
 rtl/game_pkg.sv | 35 +++
 rtl/frame_hold_timer.sv | 37 +++
 rtl/game_sequencer.sv | 118 +++++++++++
 tb/tb_game_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types, default parameters and score packing helpers for the game flow.
package game_pkg;

  typedef enum logic [2:0] {
    START   = 3'd0,
    KEEPER  = 3'd1,
    SHOOTER = 3'd2,
    WINNER  = 3'd3,
    LOOSER  = 3'd4
  } game_state_t;

  typedef enum logic {
    SOLO  = 1'b0,
    MULTI = 1'b1
  } game_mode_t;

  localparam int DEF_ROUNDS        = 5;
  localparam int DEF_MAX_KICKS     = 20;
  localparam int DEF_RESULT_FRAMES = 60;

  // Score bus layout: {player_goals[7:4], opponent_goals[3:0]}
  function automatic logic [7:0] pack_score(input logic [3:0] player,
                                            input logic [3:0] opponent);
    return {player, opponent};
  endfunction

  function automatic logic [3:0] player_goals(input logic [7:0] score);
    return score[7:4];
  endfunction

  function automatic logic [3:0] opponent_goals(input logic [7:0] score);
    return score[3:0];
  endfunction

endpackage

// File: rtl/frame_hold_timer.sv
// Counts frame_tick pulses after a load and flags done once RESULT_FRAMES have elapsed.
module frame_hold_timer #(
  parameter int RESULT_FRAMES = 60
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic frame_tick,
  output logic active,
  output logic done
);

  localparam int CW = $clog2(RESULT_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(RESULT_FRAMES);

  logic [CW-1:0] count;

  // done is high for exactly one cycle: the same edge that observes it clears active.
  assign done = active && (count == LAST);

  // Hold counter: load restarts it (a coincident tick is not counted), ticks advance it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      active <= 1'b0;
      count  <= '0;
    end else if (load) begin
      active <= 1'b1;
      count  <= '0;
    end else if (done) begin
      active <= 1'b0;
    end else if (active && frame_tick) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Penalty-shootout game-flow controller driving the display control bus.
module game_sequencer
  import game_pkg::*;
#(
  parameter int ROUNDS        = DEF_ROUNDS,
  parameter int MAX_KICKS     = DEF_MAX_KICKS,
  parameter int RESULT_FRAMES = DEF_RESULT_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        start_btn,
  input  logic        mode_sel,
  input  logic        shot_valid,
  input  logic        shot_goal,
  output game_state_t game_state,
  output game_mode_t  game_mode,
  output logic [4:0]  round_counter,
  output logic [7:0]  score,
  output logic        is_scored,
  output logic        busy
);

  localparam logic [4:0] MAX_RC = 5'(MAX_KICKS);

  // Outcome after a kick completes, judged on the updated kick count.
  function automatic game_state_t decide(input logic [4:0] rc,
                                         input logic [3:0] pg,
                                         input logic [3:0] og);
    int r, p, o, p_taken, o_taken;
    game_state_t nxt;
    r       = int'(rc);
    p       = int'(pg);
    o       = int'(og);
    p_taken = (r + 1) / 2;
    o_taken = r / 2;
    nxt     = rc[0] ? KEEPER : SHOOTER;
    if (r <= 2 * ROUNDS) begin
      // A side wins early once the other cannot catch up with its remaining kicks.
      if (p > o + (ROUNDS - o_taken))      nxt = WINNER;
      else if (o > p + (ROUNDS - p_taken)) nxt = LOOSER;
    end else if (!rc[0] && (p != o)) begin
      nxt = (p > o) ? WINNER : LOOSER;
    end
    if ((r == MAX_KICKS) && (p == o)) nxt = LOOSER;
    return nxt;
  endfunction

  logic       in_kick;
  logic       accept;
  logic       hold_done;
  logic [4:0] rc_next;
  logic [3:0] pg, og, pg_inc, og_inc;

  assign in_kick = (game_state == SHOOTER) || (game_state == KEEPER);
  assign accept  = in_kick && shot_valid && !busy;
  assign rc_next = (round_counter < MAX_RC) ? round_counter + 5'd1 : round_counter;
  assign pg      = player_goals(score);
  assign og      = opponent_goals(score);
  assign pg_inc  = (pg == 4'hF) ? pg : pg + 4'd1;
  assign og_inc  = (og == 4'hF) ? og : og + 4'd1;

  frame_hold_timer #(
    .RESULT_FRAMES (RESULT_FRAMES)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .frame_tick (frame_tick),
    .active     (busy),
    .done       (hold_done)
  );

  // Game FSM with registered control-bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_state    <= START;
      game_mode     <= MULTI;
      round_counter <= '0;
      score         <= '0;
      is_scored     <= 1'b0;
    end else begin
      case (game_state)
        START: begin
          if (start_btn) begin
            game_mode     <= game_mode_t'(mode_sel);
            round_counter <= '0;
            score         <= '0;
            is_scored     <= 1'b0;
            game_state    <= SHOOTER;
          end
        end
        SHOOTER, KEEPER: begin
          if (hold_done) begin
            round_counter <= rc_next;
            game_state    <= decide(rc_next, pg, og);
          end else if (accept) begin
            is_scored <= shot_goal;
            if (shot_goal) begin
              if (game_state == SHOOTER) score <= pack_score(pg_inc, og);
              else                       score <= pack_score(pg, og_inc);
            end
          end
        end
        WINNER, LOOSER: begin
          if (start_btn) begin
            round_counter <= '0;
            score         <= '0;
            is_scored     <= 1'b0;
            game_state    <= START;
          end
        end
        default: game_state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer (ROUNDS=5, MAX_KICKS=20, RESULT_FRAMES=2).
module tb_game_sequencer;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start_btn = 1'b0;
  logic        mode_sel = 1'b0;
  logic        shot_valid = 1'b0;
  logic        shot_goal = 1'b0;
  game_state_t game_state;
  game_mode_t  game_mode;
  logic [4:0]  round_counter;
  logic [7:0]  score;
  logic        is_scored;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  game_sequencer #(
    .ROUNDS        (5),
    .MAX_KICKS     (20),
    .RESULT_FRAMES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .start_btn     (start_btn),
    .mode_sel      (mode_sel),
    .shot_valid    (shot_valid),
    .shot_goal     (shot_goal),
    .game_state    (game_state),
    .game_mode     (game_mode),
    .round_counter (round_counter),
    .score         (score),
    .is_scored     (is_scored),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample point is 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start(input logic mode);
    mode_sel  = mode;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  task automatic shoot(input logic goal);
    shot_valid = 1'b1;
    shot_goal  = goal;
    step();
    shot_valid = 1'b0;
    shot_goal  = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Full kick: accept, two frame ticks, then the cycle where the hold releases.
  task automatic kick(input logic goal);
    shoot(goal);
    tick();
    tick();
    step();
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_state"}, 32'(game_state), 32'(START));
    check({tag, "_mode"}, 32'(game_mode), 32'(MULTI));
    check({tag, "_rc"}, 32'(round_counter), 32'd0);
    check({tag, "_score"}, 32'(score), 32'h00);
    check({tag, "_scored"}, 32'(is_scored), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values while rst_n is held low
    repeat (2) step();
    check_idle_reset("rst");
    rst_n = 1'b1;
    step();

    // Start a MULTI game, take a goal, then reset asynchronously mid-hold
    press_start(MULTI);
    check("start1_state", 32'(game_state), 32'(SHOOTER));
    shoot(1'b1);
    check("pre_rst_score", 32'(score), 32'h10);
    rst_n = 1'b0;
    #1;
    check_idle_reset("async_rst");
    step();
    rst_n = 1'b1;
    step();

    // Start SOLO
    press_start(SOLO);
    check("start2_state", 32'(game_state), 32'(SHOOTER));
    check("start2_mode", 32'(game_mode), 32'(SOLO));
    check("start2_score", 32'(score), 32'h00);
    check("start2_rc", 32'(round_counter), 32'd0);

    // Hold timing on a goal in SHOOTER
    shoot(1'b1);
    check("hold_scored", 32'(is_scored), 32'd1);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_score", 32'(score), 32'h10);
    tick();
    shoot(1'b0);
    check("hold_drop_shot_score", 32'(score), 32'h10);
    check("hold_drop_shot_scored", 32'(is_scored), 32'd1);
    tick();
    check("hold_busy_at_count", 32'(busy), 32'd1);
    check("hold_rc_at_count", 32'(round_counter), 32'd0);
    step();
    check("hold_release_busy", 32'(busy), 32'd0);
    check("hold_release_rc", 32'(round_counter), 32'd1);
    check("hold_release_state", 32'(game_state), 32'(KEEPER));

    // Tick coincident with acceptance must not count toward the new hold
    frame_tick = 1'b1;
    shoot(1'b0);
    frame_tick = 1'b0;
    check("coinc_scored", 32'(is_scored), 32'd0);
    tick();
    step();
    check("coinc_still_busy", 32'(busy), 32'd1);
    tick();
    step();
    check("coinc_release_rc", 32'(round_counter), 32'd2);
    check("coinc_release_state", 32'(game_state), 32'(SHOOTER));
    check("coinc_score", 32'(score), 32'h10);

    // start_btn mid-game is ignored
    press_start(MULTI);
    check("midgame_start_state", 32'(game_state), 32'(SHOOTER));
    check("midgame_start_mode", 32'(game_mode), 32'(SOLO));

    // Early win: player 3/3, opponent 0/3
    kick(1'b1);
    kick(1'b0);
    kick(1'b1);
    check("early_rc5_state", 32'(game_state), 32'(KEEPER));
    check("early_rc5_score", 32'(score), 32'h30);
    kick(1'b0);
    check("early_state", 32'(game_state), 32'(WINNER));
    check("early_rc", 32'(round_counter), 32'd6);
    check("early_score", 32'(score), 32'h30);
    shoot(1'b1);
    tick();
    check("frozen_state", 32'(game_state), 32'(WINNER));
    check("frozen_score", 32'(score), 32'h30);
    check("frozen_rc", 32'(round_counter), 32'd6);
    check("frozen_scored", 32'(is_scored), 32'd0);
    check("frozen_busy", 32'(busy), 32'd0);

    // Sudden death: 4-4 after regulation, player scores, opponent misses
    press_start(MULTI);
    check("restart_w_state", 32'(game_state), 32'(START));
    press_start(MULTI);
    for (int i = 0; i < 8; i++) kick(1'b1);
    kick(1'b0);
    kick(1'b0);
    check("sd_rc10", 32'(round_counter), 32'd10);
    check("sd_rc10_score", 32'(score), 32'h44);
    check("sd_rc10_state", 32'(game_state), 32'(SHOOTER));
    kick(1'b1);
    check("sd_rc11_score", 32'(score), 32'h54);
    check("sd_rc11_state", 32'(game_state), 32'(KEEPER));
    kick(1'b0);
    check("sd_rc12_state", 32'(game_state), 32'(WINNER));
    check("sd_rc12_rc", 32'(round_counter), 32'd12);

    // Cap: every kick scores, 10-10 at 20 kicks
    press_start(SOLO);
    press_start(SOLO);
    for (int i = 0; i < 19; i++) kick(1'b1);
    check("cap_rc19_state", 32'(game_state), 32'(KEEPER));
    kick(1'b1);
    check("cap_state", 32'(game_state), 32'(LOOSER));
    check("cap_rc", 32'(round_counter), 32'd20);
    check("cap_score", 32'(score), 32'hAA);
    kick(1'b1);
    check("cap_no_incr_rc", 32'(round_counter), 32'd20);
    check("cap_no_incr_score", 32'(score), 32'hAA);

    // Restart from LOOSER clears the bus in the same cycle
    check("pre_restart_scored", 32'(is_scored), 32'd1);
    press_start(MULTI);
    check("restart_state", 32'(game_state), 32'(START));
    check("restart_score", 32'(score), 32'h00);
    check("restart_rc", 32'(round_counter), 32'd0);
    check("restart_scored", 32'(is_scored), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
